// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus controller: FSM states,
// address-map constants and the decode error-cause encoding.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAM_ACC,
        PER_ACC,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_CONFLICT,
        ERR_MISALIGNED,
        ERR_UNMAPPED
    } err_cause_t;

    localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] PER_WINDOW = 32'h0001_0000;

    // Earlier checks take priority: a conflicting request is reported as such
    // even when its address is also misaligned or unmapped.
    function automatic err_cause_t classify(input logic       rd,
                                            input logic       wr,
                                            input logic [1:0] low_bits,
                                            input logic       mapped);
        if (rd && wr)
            return ERR_CONFLICT;
        else if (low_bits != 2'b00)
            return ERR_MISALIGNED;
        else if (!mapped)
            return ERR_UNMAPPED;
        else
            return ERR_NONE;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// CPU-side memory port of the bus controller. The master modport is the CPU
// core, the slave modport is the controller.
interface mem_bus_if;

    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_error;

    modport master (
        output cpu_addr,
        output cpu_wdata,
        output cpu_rd,
        output cpu_wr,
        input  cpu_rdata,
        input  cpu_ready,
        input  cpu_error
    );

    modport slave (
        input  cpu_addr,
        input  cpu_wdata,
        input  cpu_rd,
        input  cpu_wr,
        output cpu_rdata,
        output cpu_ready,
        output cpu_error
    );

endinterface

// File: rtl/mem_addr_decode.sv
// Combinational address decoder: classifies a CPU request as an SRAM hit,
// a peripheral hit or an error (conflict, misaligned, unmapped).
module mem_addr_decode
    import mem_bus_pkg::*;
#(
    parameter int          RAM_WORDS   = 1024,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000
) (
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    output logic        hit_ram,
    output logic        hit_per,
    output logic        err
);

    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic       req;
    logic       in_ram;
    logic       in_per;
    err_cause_t cause;

    // Unsigned offset compares wrap below the base, so one compare per region suffices.
    always_comb begin
        req     = rd | wr;
        in_ram  = (addr - RAM_BASE) < RAM_BYTES;
        in_per  = (addr - PERIPH_BASE) < PER_WINDOW;
        cause   = classify(rd, wr, addr[1:0], in_ram | in_per);
        err     = req && (cause != ERR_NONE);
        hit_ram = req && (cause == ERR_NONE) && in_ram;
        hit_per = req && (cause == ERR_NONE) && !in_ram && in_per;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-master memory bus controller: CPU port to SRAM and peripheral bus.
// Define MEM_BUS_TIMEOUT_EN to abort peripheral accesses after TIMEOUT cycles.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int          RAM_WORDS   = 1024,
    parameter int          RAM_WAIT    = 1,
    parameter logic [31:0] PERIPH_BASE = 32'h4000_0000,
    parameter int          TIMEOUT     = 15,
    localparam int         RAM_AW      = $clog2(RAM_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    mem_bus_if.slave          cpu,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic [15:0]       per_addr,
    output logic              per_sel,
    output logic              per_write,
    output logic [31:0]       per_wdata,
    input  logic [31:0]       per_rdata,
    input  logic              per_ack
);

`ifdef MEM_BUS_TIMEOUT_EN
    localparam int CNT_MAX = (RAM_WAIT > TIMEOUT) ? RAM_WAIT : TIMEOUT;
`else
    localparam int CNT_MAX = RAM_WAIT;
`endif
    localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               we_q, we_d;
    logic               hit_ram, hit_per, dec_err;

    logic [RAM_AW-1:0]  ram_addr_d;
    logic               ram_cs_d, ram_we_d;
    logic [31:0]        ram_wdata_d;
    logic [15:0]        per_addr_d;
    logic               per_sel_d, per_write_d;
    logic [31:0]        per_wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;

    mem_addr_decode #(
        .RAM_WORDS   (RAM_WORDS),
        .PERIPH_BASE (PERIPH_BASE)
    ) u_decode (
        .addr    (cpu.cpu_addr),
        .rd      (cpu.cpu_rd),
        .wr      (cpu.cpu_wr),
        .hit_ram (hit_ram),
        .hit_per (hit_per),
        .err     (dec_err)
    );

    // Next-state and next-output logic; every bus output is computed here one
    // cycle ahead and registered, so CPU inputs never reach a strobe directly.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        we_d        = we_q;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ram_cs_d    = 1'b0;
        ram_we_d    = 1'b0;
        per_addr_d  = per_addr;
        per_wdata_d = per_wdata;
        per_sel_d   = 1'b0;
        per_write_d = 1'b0;
        rdata_d     = '0;
        ready_d     = 1'b0;
        error_d     = 1'b0;

        case (state)
            IDLE: begin
                if (dec_err) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else if (hit_ram) begin
                    state_d     = RAM_ACC;
                    cnt_d       = CNT_W'(RAM_WAIT - 1);
                    we_d        = cpu.cpu_wr;
                    ram_addr_d  = cpu.cpu_addr[RAM_AW+1:2];
                    ram_wdata_d = cpu.cpu_wdata;
                    ram_cs_d    = 1'b1;
                    ram_we_d    = cpu.cpu_wr;
                end else if (hit_per) begin
                    state_d     = PER_ACC;
                    cnt_d       = '0;
                    we_d        = cpu.cpu_wr;
                    per_addr_d  = cpu.cpu_addr[15:0];
                    per_wdata_d = cpu.cpu_wdata;
                    per_sel_d   = 1'b1;
                    per_write_d = cpu.cpu_wr;
                end
            end

            RAM_ACC: begin
                if (cnt == '0) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (!we_q)
                        rdata_d = ram_rdata;
                end else begin
                    cnt_d    = cnt - 1'b1;
                    ram_cs_d = 1'b1;
                    ram_we_d = we_q;
                end
            end

            PER_ACC: begin
                if (per_ack) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    if (!we_q)
                        rdata_d = per_rdata;
`ifdef MEM_BUS_TIMEOUT_EN
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    ready_d = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d       = cnt + 1'b1;
                    per_sel_d   = 1'b1;
                    per_write_d = we_q;
                end
`else
                end else begin
                    per_sel_d   = 1'b1;
                    per_write_d = we_q;
                end
`endif
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Asynchronous reset abandons any access and clears every output at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            ram_addr  <= '0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            per_addr  <= '0;
            per_sel   <= 1'b0;
            per_write <= 1'b0;
            per_wdata <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            we_q      <= we_d;
            ram_addr  <= ram_addr_d;
            ram_cs    <= ram_cs_d;
            ram_we    <= ram_we_d;
            ram_wdata <= ram_wdata_d;
            per_addr  <= per_addr_d;
            per_sel   <= per_sel_d;
            per_write <= per_write_d;
            per_wdata <= per_wdata_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign cpu.cpu_rdata = rdata_q;
    assign cpu.cpu_ready = ready_q;
    assign cpu.cpu_error = error_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: SRAM and peripheral models plus a
// scoreboard of expected responses; honours MEM_BUS_TIMEOUT_EN when defined.
module tb_mem_bus_ctrl;
    import mem_bus_pkg::*;

    localparam int RAM_WORDS = 1024;
    localparam int RAM_WAIT  = 1;
    localparam int TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    mem_bus_if   cpu ();

    logic [9:0]  ram_addr;
    logic        ram_cs;
    logic        ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [15:0] per_addr;
    logic        per_sel;
    logic        per_write;
    logic [31:0] per_wdata;
    logic [31:0] per_rdata;
    logic        per_ack;

    logic [31:0] ram_mem [0:RAM_WORDS-1];
    int          per_delay = 0;
    int          per_cyc = 1;

    int          ram_cs_cnt = 0;
    int          per_sel_cnt = 0;
    int          per_wr_cnt = 0;
    int          ready_total = 0;
    logic [31:0] last_ram_addr = '0;
    logic [31:0] last_per_addr = '0;
    logic [31:0] last_per_wdata = '0;

    logic [32:0] exp_q[$];
    int          exp_ready = 0;
    int          total = 0;
    int          bad = 0;

    mem_bus_ctrl #(
        .RAM_WORDS   (RAM_WORDS),
        .RAM_WAIT    (RAM_WAIT),
        .PERIPH_BASE (32'h4000_0000),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu       (cpu),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .per_addr  (per_addr),
        .per_sel   (per_sel),
        .per_write (per_write),
        .per_wdata (per_wdata),
        .per_rdata (per_rdata),
        .per_ack   (per_ack)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read, write on the clock edge while selected.
    assign ram_rdata = ram_mem[ram_addr];
    always @(posedge clk) begin
        if (ram_cs && ram_we)
            ram_mem[ram_addr] <= ram_wdata;
    end

    // Peripheral model acks in the per_delay-th cycle of per_sel (0 = never).
    assign per_rdata = 32'hC0DE_0000 | {16'h0000, per_addr};
    assign per_ack   = per_sel && (per_delay != 0) && (per_cyc == per_delay);
    always @(posedge clk) begin
        per_cyc <= per_sel ? per_cyc + 1 : 1;
    end

    always @(negedge clk) begin
        if (ram_cs) begin
            ram_cs_cnt    <= ram_cs_cnt + 1;
            last_ram_addr <= {22'h0, ram_addr};
        end
        if (per_sel) begin
            per_sel_cnt   <= per_sel_cnt + 1;
            last_per_addr <= {16'h0, per_addr};
        end
        if (per_sel && per_write) begin
            per_wr_cnt     <= per_wr_cnt + 1;
            last_per_wdata <= per_wdata;
        end
        if (cpu.cpu_ready)
            ready_total <= ready_total + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drives one request, drops it right after acceptance, then compares the
    // response against the scoreboard entry pushed at drive time.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic rd, input logic wr,
                                 input int ack_at, input logic [31:0] exp_data,
                                 input logic exp_err, input int exp_lat,
                                 input int exp_ram, input int exp_per,
                                 input logic [31:0] exp_bus_addr);
        int          lat;
        int          ram0, per0, wr0;
        logic [32:0] exp;
        @(negedge clk);
        per_delay     = ack_at;
        cpu.cpu_addr  = addr;
        cpu.cpu_wdata = wdata;
        cpu.cpu_rd    = rd;
        cpu.cpu_wr    = wr;
        exp_q.push_back({exp_err, exp_data});
        exp_ready++;
        ram0 = ram_cs_cnt;
        per0 = per_sel_cnt;
        wr0  = per_wr_cnt;
        @(posedge clk);
        #1;
        cpu.cpu_rd    = 1'b0;
        cpu.cpu_wr    = 1'b0;
        cpu.cpu_addr  = 32'hFFFF_FFFF;
        cpu.cpu_wdata = 32'hDEAD_BEEF;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (cpu.cpu_ready) begin
                lat = n;
                break;
            end
        end
        exp = exp_q.pop_front();
        if (lat == 0) begin
            checkOutput({tag, "_no_ready"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, "_lat"}, lat, exp_lat);
        checkOutput({tag, "_data"}, cpu.cpu_rdata, exp[31:0]);
        checkOutput({tag, "_err"}, {31'h0, cpu.cpu_error}, {31'h0, exp[32]});
        #1;
        checkOutput({tag, "_ramcyc"}, ram_cs_cnt - ram0, exp_ram);
        checkOutput({tag, "_percyc"}, per_sel_cnt - per0, exp_per);
        if (exp_ram > 0)
            checkOutput({tag, "_ramaddr"}, last_ram_addr, exp_bus_addr);
        if (exp_per > 0) begin
            checkOutput({tag, "_peraddr"}, last_per_addr, exp_bus_addr);
            checkOutput({tag, "_perwrcyc"}, per_wr_cnt - wr0, wr ? exp_per : 0);
            if (wr)
                checkOutput({tag, "_perwdata"}, last_per_wdata, wdata);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL global_time_limit reached");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        logic [32:0] e;
        int          r1, r2;
        cpu.cpu_addr  = '0;
        cpu.cpu_wdata = '0;
        cpu.cpu_rd    = 1'b0;
        cpu.cpu_wr    = 1'b0;
        for (int i = 0; i < RAM_WORDS; i++)
            ram_mem[i] = 32'hA500_0000 + i;
        ram_mem[4] = 32'hE3A0_0001;

        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'h0, cpu.cpu_ready}, 32'd0);
        checkOutput("rst_cs", {31'h0, ram_cs}, 32'd0);
        checkOutput("rst_sel", {31'h0, per_sel}, 32'd0);
        checkOutput("rst_state", 32'(dut.state), 32'(IDLE));
        rst = 1'b1;

        applyStimulus("ram_rd", 32'h0000_0010, 32'h0, 1'b1, 1'b0, 0, 32'hE3A0_0001, 1'b0,
                      RAM_WAIT + 1, RAM_WAIT, 0, 32'd4);
        applyStimulus("per_wr", 32'h4000_0008, 32'h55AA_55AA, 1'b0, 1'b1, 3, 32'h0, 1'b0,
                      4, 0, 3, 32'h0008);
        applyStimulus("per_rd", 32'h4000_FFFC, 32'h0, 1'b1, 1'b0, 1, 32'hC0DE_FFFC, 1'b0,
                      2, 0, 1, 32'hFFFC);
        applyStimulus("err_misal", 32'h0000_0002, 32'h0, 1'b1, 1'b0, 0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        applyStimulus("err_unmap", 32'h8000_0000, 32'h0, 1'b1, 1'b0, 0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        applyStimulus("err_conf", 32'h0000_0010, 32'h0, 1'b1, 1'b1, 0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        applyStimulus("err_ramend", 32'h0000_1000, 32'h0, 1'b1, 1'b0, 0, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        applyStimulus("err_perend", 32'h4001_0000, 32'h0, 1'b0, 1'b1, 1, 32'h0, 1'b1, 1, 0, 0, 32'h0);
        applyStimulus("ram_wr", 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b1, 0, 32'h0, 1'b0,
                      RAM_WAIT + 1, RAM_WAIT, 0, 32'd8);
        applyStimulus("ram_rdback", 32'h0000_0020, 32'h0, 1'b1, 1'b0, 0, 32'h1234_5678, 1'b0,
                      RAM_WAIT + 1, RAM_WAIT, 0, 32'd8);

        // Back-to-back reads with the request level held across both accesses.
        @(negedge clk);
        cpu.cpu_addr = 32'h0000_0000;
        cpu.cpu_rd   = 1'b1;
        exp_q.push_back({1'b0, 32'hA500_0000});
        exp_q.push_back({1'b0, 32'hA500_0001});
        exp_ready += 2;
        r1 = 0;
        r2 = 0;
        for (int n = 1; n <= 40 && r2 == 0; n++) begin
            @(negedge clk);
            if (cpu.cpu_ready) begin
                e = exp_q.pop_front();
                checkOutput("b2b_data", cpu.cpu_rdata, e[31:0]);
                checkOutput("b2b_err", {31'h0, cpu.cpu_error}, {31'h0, e[32]});
                if (r1 == 0) begin
                    r1 = n;
                    cpu.cpu_addr = 32'h0000_0004;
                end else begin
                    r2 = n;
                end
            end
        end
        cpu.cpu_rd = 1'b0;
        if (r2 == 0)
            checkOutput("b2b_second_ready", 32'd0, 32'd1);
        else
            checkOutput("b2b_gap", r2 - r1, RAM_WAIT + 2);

`ifdef MEM_BUS_TIMEOUT_EN
        applyStimulus("per_tmo", 32'h4000_0004, 32'h0, 1'b1, 1'b0, 0, 32'h0, 1'b1,
                      TIMEOUT + 1, 0, TIMEOUT, 32'h0004);
`else
        @(negedge clk);
        per_delay    = 0;
        cpu.cpu_addr = 32'h4000_0004;
        cpu.cpu_rd   = 1'b1;
        @(posedge clk);
        #1;
        cpu.cpu_rd = 1'b0;
        repeat (100) @(negedge clk);
        checkOutput("per_wait_sel", {31'h0, per_sel}, 32'd1);
        checkOutput("per_wait_noready", ready_total, exp_ready);
        rst = 1'b0;
        #1;
        checkOutput("per_wait_rst_sel", {31'h0, per_sel}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
`endif

        // Reset asserted in the second cycle of a peripheral read.
        @(negedge clk);
        per_delay    = 0;
        cpu.cpu_addr = 32'h4000_0010;
        cpu.cpu_rd   = 1'b1;
        @(posedge clk);
        #1;
        cpu.cpu_rd = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("mid_sel_before", {31'h0, per_sel}, 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_sel", {31'h0, per_sel}, 32'd0);
        checkOutput("mid_rst_write", {31'h0, per_write}, 32'd0);
        checkOutput("mid_rst_peraddr", {16'h0, per_addr}, 32'd0);
        checkOutput("mid_rst_ready", {31'h0, cpu.cpu_ready}, 32'd0);
        checkOutput("mid_rst_error", {31'h0, cpu.cpu_error}, 32'd0);
        checkOutput("mid_rst_rdata", cpu.cpu_rdata, 32'd0);
        checkOutput("mid_rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mid_rst_noready", ready_total, exp_ready);

        applyStimulus("post_rst_rd", 32'h0000_0FFC, 32'h0, 1'b1, 1'b0, 0, 32'hA500_03FF, 1'b0,
                      RAM_WAIT + 1, RAM_WAIT, 0, 32'd1023);

        repeat (3) @(negedge clk);
        checkOutput("ready_count", ready_total, exp_ready);
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
